gate_pipe: RTL and testbench
============================

Name: gate_pipe

Overview:
- Parametrised registered gate unit for the cell-level datapath.
- Reduces NUM_IN operand words of WIDTH bits through a selectable bitwise gate: AND, OR, XOR or NAND.
- The result passes through a DEPTH-stage pipeline that has valid/ready flow control and bubble collapsing.
- Replaces the fixed 1-bit, 2-input AND-plus-flop structure used at top level, and adds an accepted-result counter.

Parameters:
- WIDTH, 8, bits per operand and result word (>=1)
- NUM_IN, 2, operand count reduced per transaction (>=2)
- DEPTH, 2, pipeline register stages from input to out_data (>=1)
- CNT_W, 16, width of the delivered-result counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set and op valid
- in_ready  output  1  pipeline can accept this cycle
- in_op  input  2  00=AND, 01=OR, 10=XOR, 11=NAND
- in_data  input  NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  result word
- out_cnt  output  CNT_W  number of results delivered

Behaviour:
- Reset is asynchronous and active-low; the clock is clk. While rst_n=0:
  - every stage valid bit = 0, every stage data register = 0
  - out_valid=0, out_data=0, out_cnt=0
  - in_ready=0 while held in reset; in_ready=1 on the first cycle after release.
- Gate function is combinational ahead of stage 1:
  - AND: bitwise AND across all NUM_IN operands
  - OR: bitwise OR across all operands
  - XOR: bitwise XOR across all operands (odd parity per bit)
  - NAND: bitwise inverse of the AND result
- Stage i (1..DEPTH) holds v[i] and d[i]. Stage DEPTH drives out_valid/out_data.
- Advance rule:
  - adv[DEPTH] = v[DEPTH] & out_ready
  - adv[i] = v[i] & (~v[i+1] | adv[i+1])
- Stage i+1 loads d[i] when adv[i]=1. Otherwise it clears its valid when adv[i+1]=1, or holds.
- in_ready = ~v[1] | adv[1]. This is combinational from out_ready through the valid chain.
- Accept: in_valid & in_ready loads the gate result into stage 1 and sets v[1].
- Latency: with no stall, a result accepted at edge N appears on out_data after edge N+DEPTH-1. Full throughput is 1 result per cycle.
- Bubbles collapse: an empty stage is filled even while stages downstream of it are stalled. Up to DEPTH results are held under a full stall.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Data registers load only on advance, never on a bubble. out_data keeps its last value when out_valid=0.
- in_op and in_data are sampled only on accept. Changes without in_valid have no effect.
- out_cnt increments by 1 on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation flushes all in-flight results immediately; no partial output is produced.
- in_valid while in_ready=0: the transaction is not taken and the source must hold it.

Optional Feature:
- Macro: GATE_PIPE_PARITY_EN.
- When defined:
  - adds output out_par (1 bit) = XOR of all out_data bits, carried as a registered bit alongside each stage
  - resets to 0
  - obeys the same hold/stall rules as out_data.
- When undefined: no out_par port and no parity registers. All other behaviour is identical.

Test Plan:
- Reset, then release:
  - held in reset: out_valid=0, out_data=0x00, out_cnt=0
  - first cycle after release: in_ready=1.
- Defaults, out_ready=1, four accepts with operands 0xF0,0x3C:
  - AND -> 0x30, OR -> 0xFC, XOR -> 0xCC, NAND -> 0xCF
  - results are on consecutive cycles, each DEPTH-1 cycles after its accept edge
  - out_cnt=4.
- out_ready=0, stream 5 XOR transactions:
  - exactly 2 accepted, then in_ready=0
  - out_data holds the first result
  - raising out_ready drains both in order, then accepts resume.
- Single-cycle stall while streaming:
  - no duplicates, no drops, order preserved
  - in_ready drops only when both stages are full.
- CNT_W=4, deliver 17 results -> out_cnt reads 1.
- Assert rst_n=0 with 2 results in flight -> out_valid=0 immediately. After release, no stale result appears.

Source files
------------

// File: rtl/gate_pipe.sv
// gate_pipe: reduces NUM_IN operand words through a selectable bitwise gate
// (AND / OR / XOR / NAND). The result travels through a DEPTH-stage valid/ready
// pipeline that collapses bubbles. A wrapping counter tracks delivered results.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready is combinational from out_ready)
//   in_op                00=AND 01=OR 10=XOR 11=NAND
//   in_data              operand k at bits [k*WIDTH +: WIDTH]
//   out_valid/out_ready  downstream handshake
//   out_data             result word (keeps its last value when out_valid=0)
//   out_cnt              results delivered, wraps at 2^CNT_W
//   out_par              (GATE_PIPE_PARITY_EN only) XOR of all out_data bits
//
// Optional feature macro: GATE_PIPE_PARITY_EN
module gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef GATE_PIPE_PARITY_EN
    output logic                    out_par,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_cnt
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [WIDTH-1:0] red_and, red_or, red_xor, gate_res;
    logic [DEPTH-1:0] v_q, v_d, adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic             alive_q, alive_d;
    logic             accept;

    always_comb begin
        red_and = in_data[WIDTH-1:0];
        red_or  = in_data[WIDTH-1:0];
        red_xor = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            red_and = red_and & in_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
        end
        case (in_op)
            OP_AND:  gate_res = red_and;
            OP_OR:   gate_res = red_or;
            OP_XOR:  gate_res = red_xor;
            OP_NAND: gate_res = ~red_and;
            default: gate_res = red_and;
        endcase
    end

    // Advance chain, evaluated from the output backwards so an empty stage
    // downstream lets its upstream neighbour move even when the output stalls.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
        for (int i = DEPTH-2; i >= 0; i--) begin
            adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
        end
    end

    assign in_ready = alive_q & (~v_q[0] | adv[0]);
    assign accept   = in_valid & in_ready;
    assign alive_d  = 1'b1;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (accept) begin
            v_d[0] = 1'b1;
            d_d[0] = gate_res;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                v_d[i] = 1'b1;
                d_d[i] = d_q[i-1];
            end else if (adv[i]) begin
                v_d[i] = 1'b0;
            end
        end
    end

    assign cnt_d = adv[DEPTH-1] ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            cnt_q   <= '0;
            alive_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_cnt   = cnt_q;

`ifdef GATE_PIPE_PARITY_EN
    // Parity bit rides alongside each data stage with identical load rules.
    logic [DEPTH-1:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (accept) p_d[0] = ^gate_res;
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) p_d[i] = p_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
    end

    assign out_par = p_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_gate_pipe.sv
module tb_gate_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_cnt;
    logic        c4_in_ready, c4_out_valid;
    logic [7:0]  c4_out_data;
    logic [3:0]  c4_out_cnt;
`ifdef GATE_PIPE_PARITY_EN
    logic        out_par, c4_out_par;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_pipe #(.WIDTH(8), .NUM_IN(2), .DEPTH(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef GATE_PIPE_PARITY_EN
        .out_par(out_par),
`endif
        .out_data(out_data), .out_cnt(out_cnt)
    );

    gate_pipe #(.WIDTH(8), .NUM_IN(2), .DEPTH(2), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(c4_in_ready), .in_op(in_op), .in_data(in_data),
        .out_valid(c4_out_valid), .out_ready(out_ready),
`ifdef GATE_PIPE_PARITY_EN
        .out_par(c4_out_par),
`endif
        .out_data(c4_out_data), .out_cnt(c4_out_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", out_data); end
        checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", out_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_gates();
        logic [7:0] exp_b [4];
        exp_b = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
        out_ready = 1'b1;
        in_data   = {8'h3C, 8'hF0};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            in_op    = 2'(i);
            step();
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_b[i-1]) begin
                    errors++;
                    $display("FAIL gate_op%0d: got v=%b d=%h exp v=1 d=%h", i-1, out_valid, out_data, exp_b[i-1]);
                end
            end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gates_drained: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'hCF) begin errors++; $display("FAIL gates_hold: got %h exp cf", out_data); end
        checks++; if (out_cnt !== 16'd4) begin errors++; $display("FAIL gates_cnt: got %0d exp 4", out_cnt); end
    endtask

    task automatic test_full_stall();
        int  sent;
        logic acc;
        sent      = 0;
        out_ready = 1'b0;
        in_op     = 2'b10;
        for (int c = 0; c < 6; c++) begin
            in_valid = (sent < 5);
            in_data  = {8'(sent + 1), 8'h0F};
            #1;
            acc = in_valid & in_ready;
            step();
            if (acc) sent++;
        end
        in_data = {8'(sent + 1), 8'h0F};
        #1;
        checks++; if (sent != 2) begin errors++; $display("FAIL stall_accepts: got %0d exp 2", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h0E) begin
            errors++; $display("FAIL stall_hold: got v=%b d=%h exp v=1 d=0e", out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready: got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h0D) begin errors++; $display("FAIL drain_second: got %h exp 0d", out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h0C) begin
            errors++; $display("FAIL resumed_accept: got v=%b d=%h exp v=1 d=0c", out_valid, out_data);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b exp 0", out_valid); end
        checks++; if (out_cnt !== 16'd7) begin errors++; $display("FAIL stall_cnt: got %0d exp 7", out_cnt); end
    endtask

    task automatic test_single_stall();
        logic [7:0]  exp_s [6];
        logic [15:0] rdy_pat;
        int   sent, recv;
        logic exp_rdy, acc, dlv;
        exp_s   = '{8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09};
        rdy_pat = 16'b1111_1111_1101_1011;
        sent = 0;
        recv = 0;
        in_op = 2'b10;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = rdy_pat[c % 16];
            in_valid  = (sent < 6);
            in_data   = {8'(sent + 1), 8'h0F};
            #1;
            exp_rdy = ((sent - recv) < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL stream_in_ready c%0d: got %b exp %b", c, in_ready, exp_rdy);
            end
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            if (dlv) begin
                checks++;
                if (out_data !== exp_s[recv]) begin
                    errors++; $display("FAIL stream_data%0d: got %h exp %h", recv, out_data, exp_s[recv]);
                end
            end
            step();
            if (acc) sent++;
            if (dlv) recv++;
        end
        in_valid = 1'b0;
        checks++; if (recv != 6) begin errors++; $display("FAIL stream_timeout: got %0d results exp 6", recv); end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra: got v=%b exp 0", out_valid); end
        checks++; if (out_cnt !== 16'd13) begin errors++; $display("FAIL stream_cnt: got %0d exp 13", out_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_data   = {8'h0A, 8'h50};
        step();
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b exp 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h exp 00", out_data); end
        checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d exp 0", out_cnt); end
        in_valid = 1'b0;
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_cnt_wrap();
        out_ready = 1'b1;
        in_op     = 2'b00;
        in_data   = {8'hFF, 8'h55};
        for (int i = 0; i < 19; i++) begin
            in_valid = (i < 17);
            step();
        end
        checks++; if (out_cnt !== 16'd17) begin errors++; $display("FAIL wrap_cnt16: got %0d exp 17", out_cnt); end
        checks++; if (c4_out_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d exp 1", c4_out_cnt); end
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL wrap_data: got %h exp 55", out_data); end
    endtask

    initial begin
        test_reset();
        test_gates();
        test_full_stall();
        test_single_stall();
        test_reset_mid();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
